clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Front-end controller for the hour/min/sec counter datapath.
- Generates the 1 Hz count enable (`ena`) and 5 Hz enable (`ena_5hz`) from the system clock.
- Debounces the three user buttons.
- Sequences the set-mode state machine that drives `select_mode`.
- Produces single-cycle `ena_up`/`ena_dw` strobes, with auto-repeat when a button is held.
- Outputs feed the counter block directly; `blink` feeds the display driver.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; must be a multiple of 5.
- DEB_CYC, 1_000_000, cycles a raw button must be stable before its clean level changes (min 1).
- HOLD_TICKS, 5, count of 5 Hz ticks a button must be held before auto-repeat starts.
- TIMEOUT_S, 30, seconds without a button edge in a set mode before returning to RUN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
- btn_up  in  1  raw increment button, active-high.
- btn_dw  in  1  raw decrement button, active-high.
- ena  out  1  1 Hz tick, one clk wide.
- ena_5hz  out  1  5 Hz tick, one clk wide.
- select_mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC.
- ena_up  out  1  increment strobe, one clk wide.
- ena_dw  out  1  decrement strobe, one clk wide.
- blink  out  1  display blink for the field being edited.

Behaviour:

Clock, reset and reset values:
- Single clock domain: clk.
- Reset is synchronous and active-high: rst.
- All outputs are 0 on reset, which also means select_mode = RUN.
- Reset clears all counters, synchronisers, debounce state and the FSM.
- Reset asserted mid-operation (e.g. during auto-repeat) takes effect on the next clk edge, with no strobe in that cycle.

Prescaler:
- Counter p counts 0..CLK_HZ/5-1.
- ena_5hz = 1 in the cycle p == CLK_HZ/5-1.
- Counter q counts 0..4 and advances on each ena_5hz.
- ena = 1 in the cycle where ena_5hz = 1 and q == 4, so ena is always coincident with an ena_5hz.
- The first ena_5hz occurs CLK_HZ/5 cycles after reset release.

Button conditioning (per button):
- 2-flop synchroniser, then debounce.
- Debounce: the clean level updates only after the synchronised input has differed from it for DEB_CYC consecutive cycles. Any glitch restarts the count.
- Press = one-cycle pulse on the rising edge of the clean level.

FSM:
- State advances on mode press: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- select_mode is the registered state; it changes in the cycle after the mode press.

Up/down strobes:
- RUN: up/dw presses and holds are ignored; ena_up = ena_dw = 0.
- Set states, up press: ena_up = 1 in the cycle after the press pulse.
- Held button: a hold counter increments on each ena_5hz while the clean level stays 1. Once the counter reaches HOLD_TICKS it saturates, and ena_up pulses in the cycle after every subsequent ena_5hz.
- Release clears the hold counter.
- dw behaves identically, producing ena_dw.
- ena_up and ena_dw are never 1 in the same cycle.

Simultaneous events:
- Clean up and dw both 1: no strobes, and both hold counters are held at 0.
- Mode press in the same cycle as an up/dw press: mode wins and that up/dw press is dropped.
- Hold counters are cleared on every state change.

Timeout:
- In set states, an idle counter increments on each ena and clears on any press pulse.
- When the counter reaches TIMEOUT_S, the state returns to RUN.
- The counter is cleared in RUN.

blink:
- Toggles on each ena_5hz while in a set state.
- Forced to 0 in RUN.
- Set to 1 on entry to each set state.

Decomposition:
- Shared package clock_pkg: 2-bit mode encodings MODE_RUN, MODE_HOUR, MODE_MIN, MODE_SEC (the same encoding the counter block decodes on select_mode), plus the mode_t typedef.
- One sub-module, btn_debounce (parameter DEB_CYC; ports clk, rst, raw, level, press), instantiated three times.
- Prescaler, FSM, auto-repeat and timeout logic live in clock_set_ctrl.

Test Plan:
All scenarios use CLK_HZ=100, DEB_CYC=4, HOLD_TICKS=5, TIMEOUT_S=3. With these values ena_5hz fires every 20 cycles and ena every 100 cycles.

1. Reset, then run 300 cycles -> ena_5hz at cycles 20, 40, …; ena at 100, 200, 300; all other outputs stay 0.
2. Pulse btn_mode for 3 cycles (glitch) -> no state change. Hold it for 10 cycles -> select_mode = 01. Three more clean presses -> 10, 11, then 00.
3. In SET_MIN, a 10-cycle btn_up press -> exactly one ena_up and no ena_dw. The same press in RUN -> no strobe.
4. In SET_HOUR, hold btn_dw for 300 cycles -> one immediate ena_dw, none for the next 5 ena_5hz ticks, then one ena_dw after each ena_5hz. Release -> strobes stop.
5. Hold btn_up and btn_dw together in SET_SEC -> zero strobes. Press mode in the same cycle as an up press -> state advances and no ena_up.
6. Enter SET_HOUR and stay idle -> return to select_mode = 00 after the 3rd ena, with blink = 0. Assert rst during auto-repeat -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared mode encodings for the clock set controller and the counter block
// that decodes select_mode.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_HOUR = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_SEC  = 2'b11
  } mode_t;

  // Mode button cycles RUN -> HOUR -> MIN -> SEC -> RUN.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:  return MODE_HOUR;
      MODE_HOUR: return MODE_MIN;
      MODE_MIN:  return MODE_SEC;
      default:   return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debounce for one raw button; press is a
// one-cycle pulse coincident with the clean level rising.
module btn_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= raw;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      // Any cycle where the input agrees with the clean level restarts the count.
      if (r_s2 != r_level) begin
        if (r_cnt == C_LAST) begin
          r_level <= r_s2;
          r_press <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-end controller for the clock counter: tick prescaler, button
// conditioning, set-mode FSM, up/down strobes with auto-repeat, and timeout.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYC    = 1_000_000,
  parameter int HOLD_TICKS = 5,
  parameter int TIMEOUT_S  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_dw,
  output logic       ena,
  output logic       ena_5hz,
  output logic [1:0] select_mode,
  output logic       ena_up,
  output logic       ena_dw,
  output logic       blink
);

  localparam int P_DIV = CLK_HZ / 5;
  localparam int P_W   = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam int H_W   = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int I_W   = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [P_W-1:0] P_LAST   = P_W'(P_DIV - 1);
  localparam logic [H_W-1:0] HOLD_MAX = H_W'(HOLD_TICKS);
  localparam logic [I_W-1:0] IDLE_MAX = I_W'(TIMEOUT_S);

  logic [P_W-1:0] r_p;
  logic [2:0]     r_q;
  logic           w_tick5;
  logic           w_tick1;

  assign w_tick5 = (r_p == P_LAST);
  assign w_tick1 = w_tick5 && (r_q == 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
      r_q <= '0;
    end else if (w_tick5) begin
      r_p <= '0;
      r_q <= (r_q == 3'd4) ? 3'd0 : r_q + 3'd1;
    end else begin
      r_p <= r_p + 1'b1;
    end
  end

  logic w_unused_mode_lvl;
  logic w_mode_prs;
  logic w_up_lvl, w_up_prs;
  logic w_dw_lvl, w_dw_prs;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .level(w_unused_mode_lvl), .press(w_mode_prs)
  );
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
    .clk(clk), .rst(rst), .raw(btn_up), .level(w_up_lvl), .press(w_up_prs)
  );
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dw (
    .clk(clk), .rst(rst), .raw(btn_dw), .level(w_dw_lvl), .press(w_dw_prs)
  );

  mode_t          r_state;
  mode_t          w_next;
  logic [I_W-1:0] r_idle;
  logic           w_set;
  logic           w_chg;
  logic           w_both;
  logic           w_any_prs;

  assign w_set     = (r_state != MODE_RUN);
  assign w_both    = w_up_lvl && w_dw_lvl;
  assign w_any_prs = w_mode_prs || w_up_prs || w_dw_prs;
  assign w_chg     = (w_next != r_state);

  // Mode press has priority over the idle timeout.
  always_comb begin
    w_next = r_state;
    if (w_mode_prs) begin
      w_next = next_mode(r_state);
    end else if (w_set && (r_idle == IDLE_MAX)) begin
      w_next = MODE_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= MODE_RUN;
    else     r_state <= w_next;
  end

  logic [H_W-1:0] r_hold_up;
  logic [H_W-1:0] r_hold_dw;
  logic           r_ena_up;
  logic           r_ena_dw;
  logic           r_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle    <= '0;
      r_hold_up <= '0;
      r_hold_dw <= '0;
      r_ena_up  <= 1'b0;
      r_ena_dw  <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      if (!w_set || w_chg || w_any_prs) r_idle <= '0;
      else if (w_tick1)                 r_idle <= r_idle + 1'b1;

      // Hold counters only run for a lone held button in a set mode.
      if (!w_set || w_chg || w_both || !w_up_lvl)   r_hold_up <= '0;
      else if (w_tick5 && (r_hold_up != HOLD_MAX)) r_hold_up <= r_hold_up + 1'b1;
      if (!w_set || w_chg || w_both || !w_dw_lvl)   r_hold_dw <= '0;
      else if (w_tick5 && (r_hold_dw != HOLD_MAX)) r_hold_dw <= r_hold_dw + 1'b1;

      r_ena_up <= w_set && !w_chg && !w_both &&
                  (w_up_prs || (w_up_lvl && w_tick5 && (r_hold_up == HOLD_MAX)));
      r_ena_dw <= w_set && !w_chg && !w_both &&
                  (w_dw_prs || (w_dw_lvl && w_tick5 && (r_hold_dw == HOLD_MAX)));

      if (w_next == MODE_RUN) r_blink <= 1'b0;
      else if (w_chg)         r_blink <= 1'b1;
      else if (w_tick5)       r_blink <= ~r_blink;
    end
  end

  assign ena         = w_tick1;
  assign ena_5hz     = w_tick5;
  assign select_mode = r_state;
  assign ena_up      = r_ena_up;
  assign ena_dw      = r_ena_dw;
  assign blink       = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with small parameters: a table of button
// actions plus hand-written prescaler, auto-repeat, timeout and reset sequences.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dw = 1'b0;
  logic       ena, ena_5hz, ena_up, ena_dw, blink;
  logic [1:0] select_mode;

  int n = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Clock and a count of clk edges since the last reset edge.
  always #5 clk = ~clk;
  always @(posedge clk) n <= rst ? 0 : n + 1;

  clock_set_ctrl #(
    .CLK_HZ(100), .DEB_CYC(4), .HOLD_TICKS(5), .TIMEOUT_S(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_dw(btn_dw),
    .ena(ena), .ena_5hz(ena_5hz), .select_mode(select_mode),
    .ena_up(ena_up), .ena_dw(ena_dw), .blink(blink)
  );

  typedef struct {
    int         mode_len;
    int         up_len;
    int         dw_len;
    logic [1:0] exp_mode;
    int         exp_up;
    int         exp_dw;
  } vec_t;

  vec_t vecs[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (n=%0d)", name, act, exp, n);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_up = 1'b0;
    btn_dw = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    repeat (10) step();
    btn_mode = 1'b0;
    repeat (20) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m, r, k, t3, cnt_up, cnt_dw, overlap, len;
    logic [1:0] prev_mode;
    logic exp_b;

    vecs[0]  = '{3,  0,  0,  2'b00, 0, 0};
    vecs[1]  = '{10, 0,  0,  2'b01, 0, 0};
    vecs[2]  = '{10, 0,  0,  2'b10, 0, 0};
    vecs[3]  = '{0,  10, 0,  2'b10, 1, 0};
    vecs[4]  = '{0,  0,  10, 2'b10, 0, 1};
    vecs[5]  = '{0,  3,  0,  2'b10, 0, 0};
    vecs[6]  = '{10, 0,  0,  2'b11, 0, 0};
    vecs[7]  = '{0,  10, 10, 2'b11, 0, 0};
    vecs[8]  = '{10, 10, 0,  2'b00, 0, 0};
    vecs[9]  = '{0,  10, 0,  2'b00, 0, 0};
    vecs[10] = '{0,  0,  10, 2'b00, 0, 0};
    vecs[11] = '{10, 0,  0,  2'b01, 0, 0};
    vecs[12] = '{10, 0,  10, 2'b10, 0, 0};
    vecs[13] = '{10, 0,  0,  2'b11, 0, 0};
    vecs[14] = '{10, 0,  0,  2'b00, 0, 0};

    // Prescaler: ena_5hz when n%20==19, ena when n%100==99; nothing else moves.
    do_reset();
    check("reset_outputs", {ena, ena_5hz, select_mode, ena_up, ena_dw, blink}, 0);
    for (int s = 0; s < 300; s++) begin
      step();
      check("ena_5hz", ena_5hz, (n % 20 == 19) ? 1 : 0);
      check("ena", ena, (n % 100 == 99) ? 1 : 0);
      check("run_quiet", {select_mode, ena_up, ena_dw, blink}, 0);
    end

    // Table of button actions applied back to back.
    do_reset();
    prev_mode = 2'b00;
    for (int i = 0; i < 15; i++) begin
      cnt_up = 0;
      cnt_dw = 0;
      overlap = 0;
      len = vecs[i].mode_len;
      if (vecs[i].up_len > len) len = vecs[i].up_len;
      if (vecs[i].dw_len > len) len = vecs[i].dw_len;
      for (int s = 0; s < len + 20; s++) begin
        btn_mode = (s < vecs[i].mode_len);
        btn_up   = (s < vecs[i].up_len);
        btn_dw   = (s < vecs[i].dw_len);
        step();
        cnt_up += int'(ena_up);
        cnt_dw += int'(ena_dw);
        if (ena_up && ena_dw) overlap++;
        if (select_mode != prev_mode) begin
          check($sformatf("vec%0d blink_on_entry", i), blink, (select_mode != 2'b00) ? 1 : 0);
          prev_mode = select_mode;
        end
      end
      check($sformatf("vec%0d select_mode", i), select_mode, vecs[i].exp_mode);
      check($sformatf("vec%0d ena_up_count", i), cnt_up, vecs[i].exp_up);
      check($sformatf("vec%0d ena_dw_count", i), cnt_dw, vecs[i].exp_dw);
      check($sformatf("vec%0d up_dw_overlap", i), overlap, 0);
      if (vecs[i].exp_mode == 2'b00) check($sformatf("vec%0d blink_run", i), blink, 0);
    end

    // Held dw in SET_HOUR: press strobe 7 edges after the raw edge, then a strobe
    // on the 6th and later 5 Hz ticks seen with the clean level high, until
    // release or until the idle timeout (3rd ena after the press) ends the set mode.
    do_reset();
    press_mode();
    m = n;
    r = m + 300;
    k = 0;
    t3 = ((m + 8 + 99) / 100) * 100 + 200;
    cnt_up = 0;
    btn_dw = 1'b1;
    for (int s = 0; s < 340; s++) begin
      if (s == 300) btn_dw = 1'b0;
      step();
      exp_b = 1'b0;
      if (n % 20 == 0 && n >= m + 7 && n - 1 <= r + 5) begin
        k++;
        if (k >= 6 && n <= t3) exp_b = 1'b1;
      end
      if (n == m + 7) exp_b = 1'b1;
      check("hold_dw ena_dw", ena_dw, exp_b);
      cnt_up += int'(ena_up);
    end
    check("hold_dw no_ena_up", cnt_up, 0);
    check("hold_dw timeout_mode", select_mode, 0);

    // Idle timeout out of SET_HOUR.
    do_reset();
    m = n;
    t3 = ((m + 8 + 99) / 100) * 100 + 200;
    btn_mode = 1'b1;
    for (int s = 0; s < t3 + 5 - m; s++) begin
      if (s == 10) btn_mode = 1'b0;
      step();
      check("timeout select_mode", select_mode, (n >= m + 7 && n <= t3) ? 1 : 0);
      if (n == m + 7) check("timeout blink_entry", blink, 1);
    end
    check("timeout blink_off", blink, 0);

    // Reset during auto-repeat of up.
    do_reset();
    press_mode();
    cnt_up = 0;
    btn_up = 1'b1;
    repeat (180) begin
      step();
      cnt_up += int'(ena_up);
    end
    check("repeat_before_rst", (cnt_up >= 2) ? 1 : 0, 1);
    rst = 1'b1;
    btn_up = 1'b0;
    step();
    check("rst_mid_repeat", {ena, ena_5hz, select_mode, ena_up, ena_dw, blink}, 0);
    rst = 1'b0;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
